roi_digit_capture: RTL and testbench

// - Successor to the single-box contour overlay: draws a parametrised ROI box on the VGA stream and binarises the ROI pixels.
// - OR-pools each SCALE x SCALE cell down to an OUT_DIM x OUT_DIM bit image and stores it in an internal frame buffer.
// - The buffer is handed to the MNIST classifier through a VALID/ACK handshake and a synchronous read port.
// - Sits between the VGA pixel pipeline and the classifier input loader.

---
 rtl/roi_digit_capture_if.sv | 31 +++
 rtl/roi_digit_capture.sv | 206 ++++++++++++++++++++
 tb/tb_roi_digit_capture.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/roi_digit_capture_if.sv
// Pixel stream, overlay output, frame handshake and cell read port of roi_digit_capture.
// The master side is the VGA pipeline / classifier; the slave side is the capture block.
interface roi_digit_capture_if;
  logic        capture_en;
  logic        contour_mode;
  logic [12:0] vga_h_cnt;
  logic [12:0] vga_v_cnt;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic [7:0]  ovl_r;
  logic [7:0]  ovl_g;
  logic [7:0]  ovl_b;
  logic        frame_valid;
  logic        frame_ack;
  logic [9:0]  ink_count;
  logic [9:0]  rd_addr;
  logic        rd_data;

  modport master (
    output capture_en, contour_mode, vga_h_cnt, vga_v_cnt, vga_r, vga_g, vga_b,
    output frame_ack, rd_addr,
    input  ovl_r, ovl_g, ovl_b, frame_valid, ink_count, rd_data
  );

  modport slave (
    input  capture_en, contour_mode, vga_h_cnt, vga_v_cnt, vga_r, vga_g, vga_b,
    input  frame_ack, rd_addr,
    output ovl_r, ovl_g, ovl_b, frame_valid, ink_count, rd_data
  );
endinterface

// File: rtl/roi_digit_capture.sv
// ROI box overlay, binarisation and SCALE x SCALE OR-pooling into an OUT_DIM^2 bit image.
// Define ROI_PINGPONG_EN for two image banks (capture continues while the classifier reads).
module roi_digit_capture #(
  parameter int          X_MIN          = 264,
  parameter int          Y_MIN          = 184,
  parameter int          OUT_DIM        = 28,
  parameter int          SCALE          = 4,
  parameter int          H_BLANK_OFFSET = 160,
  parameter int          V_BLANK_OFFSET = 45,
  parameter int          THRESHOLD      = 100,
  parameter logic [23:0] BOX_RGB        = 24'h00FF00
) (
  input logic              clk,
  input logic              rst,
  roi_digit_capture_if.slave bus
);

  localparam logic [12:0] X0 = 13'(X_MIN + H_BLANK_OFFSET);
  localparam logic [12:0] Y0 = 13'(Y_MIN + V_BLANK_OFFSET);
  localparam logic [12:0] X1 = 13'(X_MIN + H_BLANK_OFFSET + OUT_DIM * SCALE - 1);
  localparam logic [12:0] Y1 = 13'(Y_MIN + V_BLANK_OFFSET + OUT_DIM * SCALE - 1);
  localparam int CELLS = OUT_DIM * OUT_DIM;
  localparam int AW    = $clog2(CELLS);
  localparam int CW    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int SW    = (SCALE > 1) ? $clog2(SCALE) : 1;
`ifdef ROI_PINGPONG_EN
  localparam int BANKS = 2;
`else
  localparam int BANKS = 1;
`endif
  localparam int DEPTH = BANKS * CELLS;
  localparam int MW    = $clog2(DEPTH);
  localparam logic [SW-1:0] S_MAX    = SW'(SCALE - 1);
  localparam logic [CW-1:0] C_MAX    = CW'(OUT_DIM - 1);
  localparam logic [7:0]    TH       = 8'(THRESHOLD);
  localparam logic [9:0]    RD_LIMIT = 10'(CELLS);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t               state;
  logic                 frame_valid_q;
  logic [9:0]           cap_ink;
  logic [SW-1:0]        sx, sy;
  logic [CW-1:0]        cx, cy;
  logic [OUT_DIM-1:0]   line_acc;
  logic [23:0]          ovl_q;
  logic                 rd_data_q;
  logic                 mem [DEPTH];
`ifdef ROI_PINGPONG_EN
  logic                 front;
  logic [9:0]           front_ink;
`else
  logic                 ack_pend;
`endif

  logic [12:0]   h, v;
  logic [7:0]    luma;
  logic          bin, in_x, in_y, in_roi, edge_pix;
  logic          start, cap_pix, last_pix, mem_we, wbit, clear_ctx;
  logic [AW-1:0] cell_addr;
  logic [MW-1:0] wr_idx, rd_idx;
  logic [9:0]    ink_base, ink_next;

  assign h = bus.vga_h_cnt;
  assign v = bus.vga_v_cnt;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    luma      = 8'((10'(bus.vga_r) + {1'b0, bus.vga_g, 1'b0} + 10'(bus.vga_b)) >> 2);
    bin       = luma < TH;
    in_x      = (h >= X0) && (h <= X1);
    in_y      = (v >= Y0) && (v <= Y1);
    in_roi    = in_x && in_y;
    edge_pix  = ((v == Y0 || v == Y1) && in_x) || ((h == X0 || h == X1) && in_y);
    start     = (state == IDLE) && bus.capture_en && (h == X0) && (v == Y0);
    cap_pix   = in_roi && (start || (state == CAPTURE && bus.capture_en));
    last_pix  = cap_pix && (h == X1) && (v == Y1);
    mem_we    = cap_pix && (sx == S_MAX) && (sy == S_MAX);
    wbit      = line_acc[cx] | bin;
    clear_ctx = (state == IDLE && !start) || (state == CAPTURE && !bus.capture_en) ||
                (state == DONE);
    cell_addr = AW'(cy) * AW'(OUT_DIM) + AW'(cx);
`ifdef ROI_PINGPONG_EN
    wr_idx    = MW'(cell_addr) + (front ? MW'(0) : MW'(CELLS));
    rd_idx    = MW'(bus.rd_addr) + (front ? MW'(CELLS) : MW'(0));
`else
    wr_idx    = MW'(cell_addr);
    rd_idx    = MW'(bus.rd_addr);
`endif
    // The start pixel both clears the running count and may contribute to it.
    ink_base  = start ? 10'd0 : cap_ink;
    ink_next  = (mem_we && wbit && ink_base != 10'h3FF) ? ink_base + 10'd1 : ink_base;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      frame_valid_q <= 1'b0;
      cap_ink       <= '0;
      sx            <= '0;
      sy            <= '0;
      cx            <= '0;
      cy            <= '0;
      line_acc      <= '0;
`ifdef ROI_PINGPONG_EN
      front         <= 1'b0;
      front_ink     <= '0;
`else
      ack_pend      <= 1'b0;
`endif
    end else begin
      cap_ink <= ink_next;

      if (clear_ctx) begin
        sx       <= '0;
        sy       <= '0;
        cx       <= '0;
        cy       <= '0;
        line_acc <= '0;
      end else if (cap_pix) begin
        line_acc[cx] <= mem_we ? 1'b0 : wbit;
        sx <= (sx == S_MAX) ? '0 : sx + 1'b1;
        if (sx == S_MAX) cx <= (cx == C_MAX) ? '0 : cx + 1'b1;
        if (h == X1) begin
          sy <= (sy == S_MAX) ? '0 : sy + 1'b1;
          if (sy == S_MAX) cy <= (cy == C_MAX) ? '0 : cy + 1'b1;
        end
      end

`ifdef ROI_PINGPONG_EN
      if (frame_valid_q && bus.frame_ack) frame_valid_q <= 1'b0;
`else
      ack_pend <= 1'b0;
`endif

      case (state)
        IDLE: if (start) state <= CAPTURE;
        CAPTURE: begin
          if (!bus.capture_en) begin
            state <= IDLE;
          end else if (last_pix) begin
`ifdef ROI_PINGPONG_EN
            state <= IDLE;
            // An unacknowledged front image wins; the fresh back image is dropped.
            if (!frame_valid_q || bus.frame_ack) begin
              front         <= ~front;
              front_ink     <= ink_next;
              frame_valid_q <= 1'b1;
            end
`else
            state         <= DONE;
            frame_valid_q <= 1'b1;
            ack_pend      <= bus.frame_ack;
`endif
          end
        end
        DONE: begin
`ifndef ROI_PINGPONG_EN
          if (bus.frame_ack || ack_pend) begin
            state         <= IDLE;
            frame_valid_q <= 1'b0;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovl_q <= '0;
    end else if (edge_pix) begin
      ovl_q <= BOX_RGB;
    end else if (in_roi && bus.contour_mode) begin
      ovl_q <= bin ? 24'h000000 : 24'hFFFFFF;
    end else begin
      ovl_q <= {bus.vga_r, bus.vga_g, bus.vga_b};
    end
  end

  // NOTE: the image store has no reset so it maps onto block RAM; only its read register resets.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_idx] <= wbit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= 1'b0;
    else     rd_data_q <= (bus.rd_addr < RD_LIMIT) ? mem[rd_idx] : 1'b0;
  end

  assign bus.ovl_r       = ovl_q[23:16];
  assign bus.ovl_g       = ovl_q[15:8];
  assign bus.ovl_b       = ovl_q[7:0];
  assign bus.frame_valid = frame_valid_q;
  assign bus.rd_data     = rd_data_q;
`ifdef ROI_PINGPONG_EN
  assign bus.ink_count   = front_ink;
`else
  assign bus.ink_count   = cap_ink;
`endif

endmodule

// File: tb/tb_roi_digit_capture.sv
// Directed bench for roi_digit_capture: overlay vector table plus whole-frame capture,
// abort, held-off acknowledge and asynchronous reset sequences.
module tb_roi_digit_capture;
  localparam int X0 = 424;
  localparam int Y0 = 229;
  localparam int X1 = 535;
  localparam int Y1 = 340;
  localparam int N  = 28;

  typedef struct {
    int          h;
    int          v;
    logic        contour;
    logic [23:0] rgb;
    logic [23:0] exp_rgb;
  } ovl_vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  ovl_vec_t vecs [13];

  roi_digit_capture_if bus ();
  roi_digit_capture dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_ink(input int pat, input int x, input int y);
    int cx, cy;
    cx = x / 4;
    cy = y / 4;
    case (pat)
      0:       return 1'b1;
      1:       return (x == 9) && (y == 5);
      2:       return ((cx + cy) % 2 == 0) && (x % 4 == cx % 4) && (y % 4 == cy % 4);
      3:       return (cx == cy) && (x % 4 == 3) && (y % 4 == 3);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit exp_cell(input int pat, input int cx, input int cy);
    case (pat)
      0:       return 1'b1;
      1:       return (cx == 2) && (cy == 1);
      2:       return (cx + cy) % 2 == 0;
      3:       return cx == cy;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive_pix(input int h, input int v, input logic [23:0] rgb);
    bus.vga_h_cnt = 13'(h);
    bus.vga_v_cnt = 13'(v);
    {bus.vga_r, bus.vga_g, bus.vga_b} = rgb;
  endtask

  // Sweeps ROI rows r0..r1, one pixel either side of each row; ink pixels black, rest white.
  task automatic run_frame(input int pat, input int r0, input int r1, input bit expect_done);
    bit ink;
    for (int y = r0; y <= r1; y++) begin
      for (int x = -1; x <= 112; x++) begin
        ink = (x >= 0 && x <= 111) ? is_ink(pat, x, y) : 1'b0;
        drive_pix(X0 + x, Y0 + y, ink ? 24'h000000 : 24'hFFFFFF);
        if (expect_done && y == 111 && x == 111) begin
          check($sformatf("valid_before_last_p%0d", pat), bus.frame_valid, 0);
          tick();
          check($sformatf("valid_after_last_p%0d", pat), bus.frame_valid, 1);
        end else begin
          tick();
        end
      end
    end
  endtask

  task automatic check_image(input int pat, input string name);
    int mism;
    mism = 0;
    for (int a = 0; a < N * N; a++) begin
      bus.rd_addr = 10'(a);
      tick();
      if (bus.rd_data !== exp_cell(pat, a % N, a / N)) mism++;
    end
    check(name, mism, 0);
  endtask

  task automatic ack_and_check(input string name);
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    check(name, bus.frame_valid, 0);
  endtask

  initial begin
    vecs[0]  = '{X0,      Y0 + 3,  1'b1, 24'h323232, 24'h00FF00};
    vecs[1]  = '{X0 + 5,  Y0 + 5,  1'b1, 24'h323232, 24'h000000};
    vecs[2]  = '{X0 + 5,  Y0 + 5,  1'b1, 24'h969696, 24'hFFFFFF};
    vecs[3]  = '{X0 + 5,  Y0 + 5,  1'b0, 24'h0C2238, 24'h0C2238};
    vecs[4]  = '{X1,      Y1,      1'b1, 24'h000000, 24'h00FF00};
    vecs[5]  = '{X1 + 1,  Y0 + 3,  1'b1, 24'h070809, 24'h070809};
    vecs[6]  = '{X0 + 50, Y1,      1'b0, 24'h123456, 24'h00FF00};
    vecs[7]  = '{X0 + 50, Y0 - 1,  1'b1, 24'h010203, 24'h010203};
    vecs[8]  = '{X0 + 1,  Y0 + 1,  1'b1, 24'h646464, 24'hFFFFFF};
    vecs[9]  = '{X0 + 1,  Y0 + 1,  1'b1, 24'h636363, 24'h000000};
    vecs[10] = '{X0 + 60, Y0 + 60, 1'b1, 24'hFF0000, 24'h000000};
    vecs[11] = '{X0 - 1,  Y0,      1'b1, 24'h040506, 24'h040506};
    vecs[12] = '{X1,      Y0 + 50, 1'b1, 24'hFFFFFF, 24'h00FF00};

    rst = 1'b1;
    bus.capture_en   = 1'b0;
    bus.contour_mode = 1'b0;
    bus.frame_ack    = 1'b0;
    bus.rd_addr      = '0;
    drive_pix(0, 0, 24'h000000);
    #12;
    check("rst_valid", bus.frame_valid, 0);
    check("rst_ink", bus.ink_count, 0);
    check("rst_ovl", {bus.ovl_r, bus.ovl_g, bus.ovl_b}, 0);
    check("rst_rd_data", bus.rd_data, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Overlay table, no capture armed
    for (int i = 0; i < 13; i++) begin
      bus.contour_mode = vecs[i].contour;
      drive_pix(vecs[i].h, vecs[i].v, vecs[i].rgb);
      tick();
      check($sformatf("ovl_%0d", i), {bus.ovl_r, bus.ovl_g, bus.ovl_b}, vecs[i].exp_rgb);
    end
    bus.contour_mode = 1'b0;

    // T1: all-black ROI
    bus.capture_en = 1'b1;
    ack_and_check("ack_in_idle_ignored");
    run_frame(0, 0, 111, 1'b1);
    check("t1_ink", bus.ink_count, 784);
    check_image(0, "t1_image");
    bus.rd_addr = 10'd784;
    tick();
    check("rd_oob_784", bus.rd_data, 0);
    bus.rd_addr = 10'd1023;
    tick();
    check("rd_oob_1023", bus.rd_data, 0);
    check("t1_valid_held", bus.frame_valid, 1);
    ack_and_check("t1_ack_fall");

    // T4: abort mid-ROI, rest of frame must not restart capture
    run_frame(0, 0, 5, 1'b0);
    bus.capture_en = 1'b0;
    drive_pix(X0 + 40, Y0 + 6, 24'h000000);
    tick();
    bus.capture_en = 1'b1;
    check("t4_valid_after_abort", bus.frame_valid, 0);
    run_frame(0, 7, 10, 1'b0);
    check("t4_no_restart", bus.frame_valid, 0);

    // T2: single ink pixel at ROI offset (9,5) on the next full frame
    run_frame(1, 0, 111, 1'b1);
    check("t2_ink", bus.ink_count, 1);
    check_image(1, "t2_image");

    // T5: three all-black frames while unacknowledged leave the image frozen
    for (int k = 0; k < 3; k++) begin
      run_frame(0, 0, 0, 1'b0);
      run_frame(0, 111, 111, 1'b0);
    end
    check("t5_valid_held", bus.frame_valid, 1);
    check("t5_ink_frozen", bus.ink_count, 1);
    check_image(1, "t5_image_frozen");
    ack_and_check("t5_ack_fall");
    run_frame(2, 0, 111, 1'b1);
    check("t5_next_ink", bus.ink_count, 392);
    check_image(2, "t5_next_image");
    ack_and_check("t5_next_ack_fall");

    // T6: asynchronous reset in the middle of a capture
    run_frame(0, 0, 7, 1'b0);
    drive_pix(X1 + 1, Y0 + 7, 24'hFFFFFF);
    bus.rd_addr = 10'd0;
    tick();
    check("t6_pre_ink", bus.ink_count, 56);
    check("t6_pre_ovl", {bus.ovl_r, bus.ovl_g, bus.ovl_b}, 24'hFFFFFF);
    #2 rst = 1'b1;
    #1;
    check("t6_async_valid", bus.frame_valid, 0);
    check("t6_async_ink", bus.ink_count, 0);
    check("t6_async_ovl", {bus.ovl_r, bus.ovl_g, bus.ovl_b}, 0);
    check("t6_async_rd_data", bus.rd_data, 0);
    tick();
    rst = 1'b0;
    tick();
    check("t6_valid_after_rst", bus.frame_valid, 0);
    run_frame(3, 0, 111, 1'b1);
    check("t6_ink", bus.ink_count, 28);
    check_image(3, "t6_image");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
